// File: rtl/multichannel_postprocessor.sv
// multichannel_postprocessor: per-channel 2**LOG2_AVG block averager with valid/ready output register.
// Define POSTPROC_ROUND_EN to round means half toward +inf instead of plain shifting.
module multichannel_postprocessor #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int LOG2_AVG = 1,
  parameter int SIG      = 1,
  localparam int CW      = CHANNELS > 1 ? $clog2(CHANNELS) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_clr,
  input  logic             i_vld,
  output logic             i_rdy,
  input  logic [CW-1:0]    i_ch,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_vld,
  input  logic             o_rdy,
  output logic [CW-1:0]    o_ch,
  output logic [WIDTH-1:0] o_data,
  output logic             o_err
);
  // one guard bit above the window sum keeps the rounding add from overflowing
  localparam int AW = WIDTH + LOG2_AVG + 1;
  localparam int NW = LOG2_AVG > 0 ? LOG2_AVG : 1;
  localparam logic [NW-1:0] LAST = NW'((1 << LOG2_AVG) - 1);
`ifdef POSTPROC_ROUND_EN
  localparam logic [AW-1:0] RND = AW'((64'd1 << LOG2_AVG) >> 1);
`else
  localparam logic [AW-1:0] RND = '0;
`endif
  logic [AW-1:0]    acc [CHANNELS];
  logic [NW-1:0]    cnt [CHANNELS];
  logic [AW-1:0]    base, sum, rsum;
  logic [NW-1:0]    bcnt;
  logic [WIDTH-1:0] mean;
  logic             take, ok, last;
  // a clear coinciding with a sample makes that sample the first of a fresh window
  always_comb begin
    i_rdy = !o_vld || o_rdy;
    take  = i_vld && i_rdy;
    ok    = 32'(i_ch) < CHANNELS;
    base  = '0;
    bcnt  = '0;
    for (int k = 0; k < CHANNELS; k++)
      if (32'(i_ch) == k && !i_clr) begin
        base = acc[k];
        bcnt = cnt[k];
      end
    sum  = base + {{(AW-WIDTH){SIG != 0 && i_data[WIDTH-1]}}, i_data};
    rsum = sum + RND;
    mean = SIG != 0 ? WIDTH'($signed(rsum) >>> LOG2_AVG) : WIDTH'(rsum >> LOG2_AVG);
    last = bcnt == LAST;
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      for (int k = 0; k < CHANNELS; k++) begin
        acc[k] <= '0;
        cnt[k] <= '0;
      end
      o_vld  <= 1'b0;
      o_ch   <= '0;
      o_data <= '0;
      o_err  <= 1'b0;
    end else begin
      o_err <= take && !ok;
      if (take && ok && last) begin
        o_vld  <= 1'b1;
        o_ch   <= i_ch;
        o_data <= mean;
      end else if (o_rdy) o_vld <= 1'b0;
      for (int k = 0; k < CHANNELS; k++)
        if (take && ok && 32'(i_ch) == k) begin
          acc[k] <= last ? '0 : sum;
          cnt[k] <= last ? '0 : bcnt + 1'b1;
        end else if (i_clr) begin
          acc[k] <= '0;
          cnt[k] <= '0;
        end
    end
endmodule

// File: tb/tb_multichannel_postprocessor.sv
// tb_multichannel_postprocessor: directed and random stimulus against a window-sum reference model.
module tb_multichannel_postprocessor;
  localparam int N = 2;
  logic        clk = 1'b0, rstn = 1'b0;
  logic        i_clr = 1'b0, i_vld = 1'b0, o_rdy = 1'b0;
  logic [1:0]  i_ch = '0;
  logic [31:0] i_data = '0;
  logic        i_rdy, o_vld, o_err;
  logic [1:0]  o_ch;
  logic [31:0] o_data;
  logic        a_vld = 1'b0;
  logic [31:0] a_data = '0;
  logic        u_rdy, u_vld, u_err, u_ch, p_rdy, p_vld, p_err, p_ch;
  logic [31:0] u_data, p_data;
  int          checks = 0, errors = 0;
  logic        err_exp = 1'b0;
  logic [33:0] exp_q[$], got_q[$];
  longint      wsum[3];
  int          wcnt[3];

  multichannel_postprocessor #(.WIDTH(32), .CHANNELS(3), .LOG2_AVG(1), .SIG(1)) dut (
    .clk(clk), .rstn(rstn), .i_clr(i_clr), .i_vld(i_vld), .i_rdy(i_rdy), .i_ch(i_ch),
    .i_data(i_data), .o_vld(o_vld), .o_rdy(o_rdy), .o_ch(o_ch), .o_data(o_data), .o_err(o_err));
  multichannel_postprocessor #(.WIDTH(32), .CHANNELS(1), .LOG2_AVG(1), .SIG(0)) u_uns (
    .clk(clk), .rstn(rstn), .i_clr(1'b0), .i_vld(a_vld), .i_rdy(u_rdy), .i_ch(1'b0),
    .i_data(a_data), .o_vld(u_vld), .o_rdy(1'b1), .o_ch(u_ch), .o_data(u_data), .o_err(u_err));
  multichannel_postprocessor #(.WIDTH(32), .CHANNELS(1), .LOG2_AVG(0), .SIG(1)) u_pass (
    .clk(clk), .rstn(rstn), .i_clr(1'b0), .i_vld(a_vld), .i_rdy(p_rdy), .i_ch(1'b0),
    .i_data(a_data), .o_vld(p_vld), .o_rdy(1'b1), .o_ch(p_ch), .o_data(p_data), .o_err(p_err));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mean_of(input longint s);
    longint q;
`ifdef POSTPROC_ROUND_EN
    s = s + N / 2;
`endif
    q = s / N;
    if (s % N != 0 && s < 0) q = q - 1;
    return 32'(q);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 3; k++) begin
      wsum[k] = 0;
      wcnt[k] = 0;
    end
    exp_q.delete();
    err_exp = 1'b0;
  endfunction

  task automatic step(input logic v, input logic [1:0] c, input logic [31:0] d,
                      input logic r = 1'b1, input logic cl = 1'b0);
    logic take;
    @(negedge clk);
    i_vld = v; i_ch = c; i_data = d; o_rdy = r; i_clr = cl;
    #1;
    check("o_err", 64'(o_err), 64'(err_exp));
    check("o_vld", 64'(o_vld), 64'(exp_q.size() != 0));
    if (exp_q.size() != 0) check("o_mean", 64'({o_ch, o_data}), 64'(exp_q[0]));
    check("i_rdy", 64'(i_rdy), 64'(exp_q.size() == 0 || r));
    take = v && (exp_q.size() == 0 || r);
    if (exp_q.size() != 0 && r) begin
      got_q.push_back({o_ch, o_data});
      void'(exp_q.pop_front());
    end
    err_exp = 1'b0;
    if (cl)
      for (int k = 0; k < 3; k++) begin
        wsum[k] = 0;
        wcnt[k] = 0;
      end
    if (take) begin
      if (c >= 3) err_exp = 1'b1;
      else begin
        wsum[c] += longint'($signed(d));
        wcnt[c]++;
        if (wcnt[c] == N) begin
          exp_q.push_back({c, mean_of(wsum[c])});
          wsum[c] = 0;
          wcnt[c] = 0;
        end
      end
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 3))
      0: return $urandom;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      default: return 32'($urandom_range(0, 40)) - 32'd20;
    endcase
  endfunction

  initial begin
    model_reset();
    #12;
    check("rst_vld", 64'(o_vld), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_ch", 64'(o_ch), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
    @(negedge clk);
    rstn = 1'b1;
    // back-to-back windows
    got_q.delete();
    step(1, 0, 1); step(1, 0, -2); step(1, 1, 3); step(1, 1, 4); step(0, 0, 0); step(0, 0, 0);
    check("t1_n", 64'(got_q.size()), 64'd2);
`ifdef POSTPROC_ROUND_EN
    check("t1_ch0", 64'(got_q[0]), 64'({2'd0, 32'd0}));
    check("t1_ch1", 64'(got_q[1]), 64'({2'd1, 32'd4}));
`else
    check("t1_ch0", 64'(got_q[0]), 64'({2'd0, 32'hFFFF_FFFF}));
    check("t1_ch1", 64'(got_q[1]), 64'({2'd1, 32'd3}));
`endif
    // interleaved channels
    got_q.delete();
    step(1, 0, 10); step(1, 1, 20); step(1, 0, 12); step(1, 1, -20); step(0, 0, 0); step(0, 0, 0);
    check("t2_n", 64'(got_q.size()), 64'd2);
    check("t2_a", 64'(got_q[0]), 64'({2'd0, 32'd11}));
    check("t2_b", 64'(got_q[1]), 64'({2'd1, 32'd0}));
    // backpressure
    got_q.delete();
    step(1, 0, 5); step(1, 0, 7, 0);
    for (int i = 0; i < 5; i++) step(1, 1, 100, 0);
    step(0, 0, 0); step(0, 0, 0);
    check("t3_n", 64'(got_q.size()), 64'd1);
    check("t3_v", 64'(got_q[0]), 64'({2'd0, 32'd6}));
    // clear discards a partial window
    got_q.delete();
    step(1, 0, 7); step(0, 0, 0, 1, 1); step(1, 0, 1); step(1, 0, 3); step(0, 0, 0); step(0, 0, 0);
    check("t4_n", 64'(got_q.size()), 64'd1);
    check("t4_v", 64'(got_q[0]), 64'({2'd0, 32'd2}));
    // out-of-range channel
    got_q.delete();
    step(1, 3, 9); step(0, 0, 0); step(1, 0, 4); step(1, 0, 6); step(0, 0, 0); step(0, 0, 0);
    check("t5_n", 64'(got_q.size()), 64'd1);
    check("t5_v", 64'(got_q[0]), 64'({2'd0, 32'd5}));
    // random traffic
    for (int i = 0; i < 800; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0 ? 2'd3 : 2'($urandom_range(0, 2)),
           pick(), $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0);
    // reset mid-window with a stalled mean pending
    step(1, 1, 50); step(1, 0, 8, 0); step(1, 0, 8, 0); step(0, 0, 0, 0);
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("rst2_vld", 64'(o_vld), 64'd0);
    check("rst2_data", 64'(o_data), 64'd0);
    check("rst2_ch", 64'(o_ch), 64'd0);
    check("rst2_err", 64'(o_err), 64'd0);
    model_reset();
    i_vld = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    got_q.delete();
    step(1, 1, 60); step(0, 0, 0); step(1, 1, 62); step(0, 0, 0); step(0, 0, 0);
    check("rst2_n", 64'(got_q.size()), 64'd1);
    check("rst2_v", 64'(got_q[0]), 64'({2'd1, 32'd61}));
    // unsigned averaging and pass-through instances
    @(negedge clk);
    a_vld = 1'b1; a_data = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    check("pass_v1", 64'(p_vld), 64'd1);
    check("pass_d1", 64'(p_data), 64'hFFFF_FFFF);
    check("uns_v1", 64'(u_vld), 64'd0);
    @(negedge clk); #1;
    check("uns_v2", 64'(u_vld), 64'd1);
    check("uns_d2", 64'(u_data), 64'hFFFF_FFFF);
    check("pass_d2", 64'(p_data), 64'hFFFF_FFFF);
    a_data = 32'h1234_5678;
    @(negedge clk); #1;
    check("pass_d3", 64'(p_data), 64'h1234_5678);
    check("uns_v3", 64'(u_vld), 64'd0);
    a_vld = 1'b0;
    @(negedge clk); #1;
    check("pass_v4", 64'(p_vld), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
